// File: rtl/park_pkg.sv
// Shared types and sizes for the parking-lot slot manager.
package park_pkg;

    localparam int unsigned SLOT_W  = 3;
    localparam int unsigned TOKEN_W = 3;
    localparam int unsigned N_SLOTS = 8;
    localparam int unsigned FREE_W  = 4;

    typedef logic [SLOT_W-1:0]  slot_t;
    typedef logic [TOKEN_W-1:0] token_t;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        ISSUE,
        CHECK,
        GATE
    } state_t;

endpackage

// File: rtl/park_manager_token_production.sv
// Combinational token generator: slot number rotated left by one, mixed with the driver pattern.
module token_production
    import park_pkg::*;
(
    input  logic [SLOT_W-1:0]  park_number,
    input  logic [TOKEN_W-1:0] pattern,
    output logic [TOKEN_W-1:0] token
);

    assign token = pattern ^ {park_number[SLOT_W-2:0], park_number[SLOT_W-1]};

endmodule

// File: rtl/park_manager.sv
// Parking-lot slot manager: allocates the lowest free slot on entry, issues a token,
// and validates slot/token pairs on exit before opening the gate.
module park_manager
    import park_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                car_in,
    input  logic [TOKEN_W-1:0]  pattern,
    input  logic                car_out,
    input  logic [SLOT_W-1:0]   exit_park,
    input  logic [TOKEN_W-1:0]  exit_token,
    output logic [SLOT_W-1:0]   park_number,
    output logic [TOKEN_W-1:0]  token,
    output logic                issue_valid,
    output logic                full_err,
    output logic                exit_err,
    output logic                gate_open,
    output logic [FREE_W-1:0]   free_count,
    output logic                busy
);

    localparam int unsigned CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    state_t              state, state_nxt;
    slot_t               exit_slot_q;
    token_t              exit_tok_q;
    token_t              pattern_q;
    logic [N_SLOTS-1:0]  occupancy;
    token_t              store [N_SLOTS];
    logic [CNT_W-1:0]    gate_cnt;
    slot_t               free_slot;
    token_t              new_token;
    logic                lot_full;
    logic                exit_hit;
    logic [FREE_W-1:0]   occ_cnt;

    function automatic slot_t lowest_free(input logic [N_SLOTS-1:0] occ);
        slot_t s;
        logic  found;
        s     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!occ[i] && !found) begin
                s     = slot_t'(i);
                found = 1'b1;
            end
        end
        return s;
    endfunction

    assign free_slot = lowest_free(occupancy);
    assign lot_full  = &occupancy;
    assign exit_hit  = occupancy[exit_slot_q] && (store[exit_slot_q] == exit_tok_q);

    token_production u_token_production (
        .park_number (free_slot),
        .pattern     (pattern_q),
        .token       (new_token)
    );

    always_comb begin
        occ_cnt = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            occ_cnt = occ_cnt + FREE_W'(occupancy[i]);
        end
        free_count = FREE_W'(N_SLOTS) - occ_cnt;
    end

    assign gate_open = (state == GATE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (car_out)     state_nxt = CHECK;
                else if (car_in) state_nxt = ALLOC;
            end
            ALLOC:   state_nxt = lot_full ? IDLE : ISSUE;
            ISSUE:   state_nxt = IDLE;
            CHECK:   state_nxt = exit_hit ? GATE : IDLE;
            GATE:    state_nxt = (gate_cnt == '0) ? IDLE : GATE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Slot, token and occupancy commit on leaving ALLOC so that ISSUE presents
    // issue_valid, park_number, token and the decremented free_count together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exit_slot_q <= '0;
            exit_tok_q  <= '0;
            pattern_q   <= '0;
            occupancy   <= '0;
            gate_cnt    <= '0;
            park_number <= '0;
            token       <= '0;
            issue_valid <= 1'b0;
            full_err    <= 1'b0;
            exit_err    <= 1'b0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                store[i] <= '0;
            end
        end else begin
            issue_valid <= 1'b0;
            full_err    <= 1'b0;
            exit_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (car_out) begin
                        exit_slot_q <= exit_park;
                        exit_tok_q  <= exit_token;
                    end else if (car_in) begin
                        pattern_q <= pattern;
                    end
                end
                ALLOC: begin
                    if (lot_full) begin
                        full_err <= 1'b1;
                    end else begin
                        park_number          <= free_slot;
                        token                <= new_token;
                        issue_valid          <= 1'b1;
                        occupancy[free_slot] <= 1'b1;
                        store[free_slot]     <= new_token;
                    end
                end
                CHECK: begin
                    if (exit_hit) begin
                        occupancy[exit_slot_q] <= 1'b0;
                        gate_cnt               <= CNT_W'(GATE_CYCLES - 1);
                    end else begin
                        exit_err <= 1'b1;
                    end
                end
                GATE: begin
                    if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_park_manager.sv
// Self-checking bench for park_manager: directed scenarios then randomized traffic
// against a transaction-level model of the lot.
module tb_park_manager;

    localparam int GATE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       car_in;
    logic [2:0] pattern;
    logic       car_out;
    logic [2:0] exit_park;
    logic [2:0] exit_token;
    logic [2:0] park_number;
    logic [2:0] token;
    logic       issue_valid;
    logic       full_err;
    logic       exit_err;
    logic       gate_open;
    logic [3:0] free_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bit m_occ   [8];
    int m_store [8];
    int m_last_park;
    int m_last_tok;

    park_manager #(.GATE_CYCLES(GATE_CYCLES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .car_in      (car_in),
        .pattern     (pattern),
        .car_out     (car_out),
        .exit_park   (exit_park),
        .exit_token  (exit_token),
        .park_number (park_number),
        .token       (token),
        .issue_valid (issue_valid),
        .full_err    (full_err),
        .exit_err    (exit_err),
        .gate_open   (gate_open),
        .free_count  (free_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference token: rotate the 3-bit slot left by one, XOR with the pattern.
    function automatic int tok_model(input int slot, input int pat);
        return (((slot * 2) % 8) + (slot / 4)) ^ pat;
    endfunction

    function automatic int model_free();
        int n = 8;
        for (int i = 0; i < 8; i++) if (m_occ[i]) n--;
        return n;
    endfunction

    function automatic int model_lowest_free();
        for (int i = 0; i < 8; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_occ[i]   = 1'b0;
            m_store[i] = 0;
        end
        m_last_park = 0;
        m_last_tok  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_iv"},   int'(issue_valid), 0);
        check({tag, "_ferr"}, int'(full_err), 0);
        check({tag, "_xerr"}, int'(exit_err), 0);
        check({tag, "_gate"}, int'(gate_open), 0);
        check({tag, "_pn"},   int'(park_number), 0);
        check({tag, "_tok"},  int'(token), 0);
        check({tag, "_free"}, int'(free_count), 8);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; car_in = 1'b0; car_out = 1'b0;
        tick();
        check_reset_outputs(tag);
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic do_entry(input int pat);
        int s, expt;
        car_in = 1'b1; pattern = pat[2:0];
        tick();
        car_in = 1'b0;
        check("entry_busy", int'(busy), 1);
        tick();
        s = model_lowest_free();
        if (s < 0) begin
            check("full_err",  int'(full_err), 1);
            check("full_iv",   int'(issue_valid), 0);
            check("full_free", int'(free_count), 0);
            check("full_busy", int'(busy), 0);
            check("full_hold", int'(park_number), m_last_park);
        end else begin
            expt = tok_model(s, pat);
            m_occ[s] = 1'b1; m_store[s] = expt;
            m_last_park = s; m_last_tok = expt;
            check("issue_iv",   int'(issue_valid), 1);
            check("issue_pn",   int'(park_number), s);
            check("issue_tok",  int'(token), expt);
            check("issue_free", int'(free_count), model_free());
            check("issue_ferr", int'(full_err), 0);
            tick();
            check("post_iv",    int'(issue_valid), 0);
            check("post_busy",  int'(busy), 0);
            check("hold_pn",    int'(park_number), m_last_park);
            check("hold_tok",   int'(token), m_last_tok);
        end
    endtask

    task automatic do_exit(input int slot, input int tok, input bit with_car_in);
        bit acc;
        acc = m_occ[slot] && (m_store[slot] == tok);
        car_out = 1'b1; exit_park = 3'(slot); exit_token = 3'(tok);
        car_in = with_car_in; pattern = 3'($urandom_range(7));
        tick();
        car_out = 1'b0;
        check("exit_busy", int'(busy), 1);
        tick();
        if (acc) begin
            m_occ[slot] = 1'b0;
            for (int g = 0; g < GATE_CYCLES; g++) begin
                check("gate_open", int'(gate_open), 1);
                check("gate_iv",   int'(issue_valid), 0);
                check("gate_free", int'(free_count), model_free());
                tick();
            end
            car_in = 1'b0;
            check("gate_closed", int'(gate_open), 0);
            check("gate_busy",   int'(busy), 0);
            tick();
        end else begin
            check("xerr",      int'(exit_err), 1);
            check("xerr_gate", int'(gate_open), 0);
            check("xerr_free", int'(free_count), model_free());
            check("xerr_busy", int'(busy), 0);
            car_in = 1'b0;
            tick();
            check("xerr_pulse", int'(exit_err), 0);
        end
        check("exit_no_iv", int'(issue_valid), 0);
        check("exit_idle",  int'(busy), 0);
    endtask

    initial begin
        int s, t, op;
        rst_n = 1'b0; car_in = 1'b0; car_out = 1'b0;
        pattern = '0; exit_park = '0; exit_token = '0;
        model_clear();
        tick();
        do_reset("rst0");

        // Single entry, pattern 5.
        do_entry(5);

        // Fill all eight, ninth refused.
        do_reset("rst1");
        for (int p = 0; p < 8; p++) do_entry(p);
        do_entry(3);

        // Free slot 1, gate timing, slot 1 reused.
        do_reset("rst2");
        for (int p = 0; p < 3; p++) do_entry(int'($urandom_range(7)));
        do_exit(1, m_store[1], 1'b0);
        check("free_after_exit", int'(free_count), 6);
        do_entry(6);
        check("reuse_slot1", int'(park_number), 1);

        // Wrong token, then empty slot.
        do_exit(2, m_store[2] ^ 1, 1'b0);
        do_exit(5, 0, 1'b0);
        check("free_after_rejects", int'(free_count), 5);

        // Simultaneous car_in/car_out, and car_in held while busy.
        do_exit(0, m_store[0], 1'b1);

        // Reset during ALLOC.
        car_in = 1'b1; pattern = 3'd2;
        tick();
        car_in = 1'b0;
        check("alloc_state_busy", int'(busy), 1);
        do_reset("rst_alloc");

        // Reset during GATE.
        do_entry(4);
        car_out = 1'b1; exit_park = 3'd0; exit_token = 3'(m_store[0]);
        tick();
        car_out = 1'b0;
        tick();
        tick();
        check("pre_rst_gate", int'(gate_open), 1);
        do_reset("rst_gate");

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            op = int'($urandom_range(9));
            if (op < 4) begin
                do_entry(int'($urandom_range(7)));
            end else if (op < 7) begin
                s = int'($urandom_range(7));
                t = (m_occ[s] && $urandom_range(1) == 1) ? m_store[s] : int'($urandom_range(7));
                do_exit(s, t, 1'b0);
            end else if (op < 9) begin
                s = int'($urandom_range(7));
                do_exit(s, m_store[s], $urandom_range(1) == 1);
            end else begin
                do_reset("rst_rand");
            end
            check("rand_free", int'(free_count), model_free());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
